commit_trace_checker: RTL and testbench

//  Consumer of the CPU retire stream (commit, commit_pc, commit_pre_pc, instr). Checks PC

---
 rtl/commit_trace_checker_pkg.sv | 30 +++
 rtl/commit_trace_checker_if.sv | 23 ++
 rtl/commit_trace_checker_trace_fifo.sv | 47 ++++
 rtl/commit_trace_checker.sv | 110 +++++++++++
 tb/tb_commit_trace_checker.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_checker_pkg.sv
// Shared encodings, trace entry layout and saturating-increment helpers for the retire-stream checker.
package commit_trace_checker_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_FIRST_PC = 3'd1;
  localparam logic [2:0] ERR_SEQ      = 3'd2;
  localparam logic [2:0] ERR_ALIGN    = 3'd3;
  localparam logic [2:0] ERR_WDOG     = 3'd4;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_ent_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/commit_trace_checker_if.sv
// Retire-stream input plus ready/valid trace read-out; master = CPU/reader side, slave = checker.
interface commit_trace_checker_if;

  logic        commit;
  logic [31:0] commit_pc;
  logic [31:0] commit_pre_pc;
  logic [31:0] instr;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;

  modport master (
    output commit, commit_pc, commit_pre_pc, instr, trace_ready,
    input  trace_valid, trace_pc, trace_instr
  );

  modport slave (
    input  commit, commit_pc, commit_pre_pc, instr, trace_ready,
    output trace_valid, trace_pc, trace_instr
  );

endinterface

// File: rtl/commit_trace_checker_trace_fifo.sv
// Synchronous trace FIFO, write-to-read latency 1 cycle; a push into a full FIFO is only taken
// when a pop happens in the same cycle, otherwise it is discarded (caller accounts for drops).
module commit_trace_checker_trace_fifo
  import commit_trace_checker_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  trace_ent_t wdat,
  output trace_ent_t rdat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  trace_ent_t       mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdat    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdat;
  end

endmodule

// File: rtl/commit_trace_checker.sv
// Retire-stream checker: PC continuity/alignment, retire counting, EBREAK/watchdog detection;
// status updates 1 cycle after the sampled commit; trace FIFO drops (and counts) when full and not read.
module commit_trace_checker
  import commit_trace_checker_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter int          TIMEOUT      = 1024,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EBREAK_INSTR = EBREAK_WORD
) (
  input  logic                   clk,
  input  logic                   rst,
  commit_trace_checker_if.slave  bus,
  output logic [31:0]            retired_cnt,
  output logic [15:0]            drop_cnt,
  output logic                   overflow,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             err_code
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [1:0]     state;
  logic [31:0]    last_pc;
  logic [WDW-1:0] wd_cnt;
  logic [2:0]     chk_code;
  logic           accept;
  logic           wd_fire;
  logic           pop;
  logic           full;
  logic           empty;
  trace_ent_t     wdat;
  trace_ent_t     rdat;

  assign accept  = bus.commit && ((state == ST_IDLE) || (state == ST_RUN));
  assign wd_fire = (state == ST_RUN) && !bus.commit && (wd_cnt == WDW'(TIMEOUT - 1));
  assign pop     = !empty && bus.trace_ready;

  // Alignment outranks PC value; in IDLE the PC mismatch is reported as a bad first PC.
  always_comb begin
    chk_code = ERR_NONE;
    if (bus.commit_pc[1:0] != 2'b00)
      chk_code = ERR_ALIGN;
    else if ((state == ST_IDLE) && (bus.commit_pc != RESET_PC))
      chk_code = ERR_FIRST_PC;
    else if ((state == ST_RUN) && (bus.commit_pre_pc != last_pc))
      chk_code = ERR_SEQ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      err_code    <= ERR_NONE;
      last_pc     <= '0;
      wd_cnt      <= '0;
      retired_cnt <= '0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
    end else begin
      if (accept) begin
        retired_cnt <= sat_inc32(retired_cnt);
        last_pc     <= bus.commit_pc;
        wd_cnt      <= '0;
        if (chk_code != ERR_NONE) begin
          state    <= ST_ERR;
          err_code <= chk_code;
        end else if (bus.instr == EBREAK_INSTR) begin
          state <= ST_DONE;
        end else begin
          state <= ST_RUN;
        end
      end else if (state == ST_RUN) begin
        wd_cnt <= wd_cnt + WDW'(1);
        if (wd_fire) begin
          state    <= ST_ERR;
          err_code <= ERR_WDOG;
        end
      end
      if (accept && full && !pop) begin
        drop_cnt <= sat_inc16(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

  assign done  = (state == ST_DONE);
  assign error = (state == ST_ERR);

  assign wdat.pc    = bus.commit_pc;
  assign wdat.instr = bus.instr;

  commit_trace_checker_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdat  (wdat),
    .rdat  (rdat),
    .full  (full),
    .empty (empty)
  );

  assign bus.trace_valid = !empty;
  assign bus.trace_pc    = rdat.pc;
  assign bus.trace_instr = rdat.instr;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker: vector table for the normal stream, hand sequences for corners.
module tb_commit_trace_checker;
  import commit_trace_checker_pkg::*;

  localparam int          DEPTH   = 16;
  localparam int          TIMEOUT = 1024;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] EBRK    = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] retired_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        done;
  logic        error;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;

  commit_trace_checker_if tif ();

  commit_trace_checker #(
    .DEPTH        (DEPTH),
    .TIMEOUT      (TIMEOUT),
    .RESET_PC     (32'h0000_0000),
    .EBREAK_INSTR (EBRK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (tif.slave),
    .retired_cnt (retired_cnt),
    .drop_cnt    (drop_cnt),
    .overflow    (overflow),
    .done        (done),
    .error       (error),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        commit;
    logic [31:0] pc;
    logic [31:0] pre_pc;
    logic [31:0] instr;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_tpc;
    logic [31:0] exp_tinstr;
    logic [31:0] exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [31:0] cnt, input logic err,
                            input logic [2:0] code, input logic dn);
    chk({tag, "_cnt"},   retired_cnt,     cnt);
    chk({tag, "_error"}, 32'(error),      32'(err));
    chk({tag, "_code"},  32'(err_code),   32'(code));
    chk({tag, "_done"},  32'(done),       32'(dn));
  endtask

  // Inputs are driven on the falling edge; outputs are read on the next falling edge.
  task automatic step(input logic c, input logic [31:0] pc, input logic [31:0] pre,
                      input logic [31:0] ins, input logic rdy);
    tif.commit        = c;
    tif.commit_pc     = pc;
    tif.commit_pre_pc = pre;
    tif.instr         = ins;
    tif.trace_ready   = rdy;
    @(posedge clk);
    @(negedge clk);
    tif.commit = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, 32'h0, 32'h0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    tif.commit      = 1'b0;
    tif.trace_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tif.commit        = 1'b0;
    tif.commit_pc     = '0;
    tif.commit_pre_pc = '0;
    tif.instr         = '0;
    tif.trace_ready   = 1'b0;
    rst               = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{1'b1, 32'h0, 32'h0, NOP, 1'b1, 1'b1, 32'h0, NOP,   32'd1, 1'b0};
    vecs[1] = '{1'b1, 32'h4, 32'h0, NOP, 1'b1, 1'b1, 32'h4, NOP,   32'd2, 1'b0};
    vecs[2] = '{1'b1, 32'h8, 32'h4, NOP, 1'b1, 1'b1, 32'h8, NOP,   32'd3, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd3, 1'b0};

    chk("rst_valid",    32'(tif.trace_valid), 32'd0);
    chk("rst_tpc",      tif.trace_pc,         32'd0);
    chk("rst_tinstr",   tif.trace_instr,      32'd0);
    chk("rst_drop",     32'(drop_cnt),        32'd0);
    chk("rst_overflow", 32'(overflow),        32'd0);
    chk_status("rst", 32'd0, 1'b0, ERR_NONE, 1'b0);

    // Watchdog must stay quiet in IDLE for far longer than TIMEOUT.
    idle(2000, 1'b0);
    chk("idle_valid", 32'(tif.trace_valid), 32'd0);
    chk_status("idle", 32'd0, 1'b0, ERR_NONE, 1'b0);

    for (int i = 0; i < 4; i++) begin
      step(vecs[i].commit, vecs[i].pc, vecs[i].pre_pc, vecs[i].instr, vecs[i].ready);
      chk($sformatf("vec%0d_valid", i),  32'(tif.trace_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_tpc", i),    tif.trace_pc,         vecs[i].exp_tpc);
      chk($sformatf("vec%0d_tinstr", i), tif.trace_instr,      vecs[i].exp_tinstr);
      chk($sformatf("vec%0d_cnt", i),    retired_cnt,          vecs[i].exp_cnt);
      chk($sformatf("vec%0d_err", i),    32'(error),           32'(vecs[i].exp_err));
    end

    // Sequence break: failing commit still counted and pushed, later commits ignored.
    do_reset();
    step(1'b1, 32'h0, 32'h0, NOP, 1'b0);
    step(1'b1, 32'h8, 32'h4, NOP, 1'b0);
    chk_status("seq", 32'd2, 1'b1, ERR_SEQ, 1'b0);
    step(1'b1, 32'hC, 32'h8, NOP, 1'b0);
    chk_status("seq_after", 32'd2, 1'b1, ERR_SEQ, 1'b0);
    chk("seq_head0", tif.trace_pc, 32'h0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("seq_head1", tif.trace_pc, 32'h8);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("seq_drained", 32'(tif.trace_valid), 32'd0);

    do_reset();
    step(1'b1, 32'h2, 32'h0, NOP, 1'b0);
    chk_status("align", 32'd1, 1'b1, ERR_ALIGN, 1'b0);
    do_reset();
    step(1'b1, 32'h4, 32'h0, NOP, 1'b0);
    chk_status("first_pc", 32'd1, 1'b1, ERR_FIRST_PC, 1'b0);
    do_reset();
    step(1'b1, 32'h6, 32'h0, NOP, 1'b0);
    chk_status("align_prio", 32'd1, 1'b1, ERR_ALIGN, 1'b0);

    // Overflow: DEPTH+3 commits with the reader stalled, then a push into full with a pop.
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++)
      step(1'b1, 32'(4 * i), (i == 0) ? 32'h0 : 32'(4 * (i - 1)), NOP, 1'b0);
    chk("ovf_drop",     32'(drop_cnt), 32'd3);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk_status("ovf", 32'(DEPTH + 3), 1'b0, ERR_NONE, 1'b0);
    step(1'b1, 32'(4 * (DEPTH + 3)), 32'(4 * (DEPTH + 2)), NOP, 1'b1);
    chk("ovf_pushpop_drop", 32'(drop_cnt), 32'd3);
    chk("ovf_pushpop_cnt",  retired_cnt,   32'(DEPTH + 4));
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(tif.trace_valid), 32'd1);
      chk($sformatf("drain%0d_pc", k), tif.trace_pc,
          (k < DEPTH - 1) ? 32'(4 * (k + 1)) : 32'(4 * (DEPTH + 3)));
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    end
    chk("drain_empty", 32'(tif.trace_valid), 32'd0);

    // Watchdog fires on the TIMEOUT-th idle RUN cycle.
    do_reset();
    step(1'b1, 32'h0, 32'h0, NOP, 1'b0);
    idle(TIMEOUT - 1, 1'b1);
    chk_status("wd_pre", 32'd1, 1'b0, ERR_NONE, 1'b0);
    idle(1, 1'b1);
    chk_status("wd_fire", 32'd1, 1'b1, ERR_WDOG, 1'b0);

    // A commit in the TIMEOUT cycle pre-empts the watchdog.
    do_reset();
    step(1'b1, 32'h0, 32'h0, NOP, 1'b0);
    idle(TIMEOUT - 1, 1'b1);
    step(1'b1, 32'h4, 32'h0, NOP, 1'b1);
    chk_status("wd_save", 32'd2, 1'b0, ERR_NONE, 1'b0);

    do_reset();
    step(1'b1, 32'h0, 32'h0, NOP, 1'b0);
    step(1'b1, 32'h4, 32'h0, EBRK, 1'b0);
    chk_status("ebreak", 32'd2, 1'b0, ERR_NONE, 1'b1);
    step(1'b1, 32'h8, 32'h4, NOP, 1'b0);
    chk_status("ebreak_after", 32'd2, 1'b0, ERR_NONE, 1'b1);

    do_reset();
    step(1'b1, 32'h0, 32'h0, NOP, 1'b0);
    step(1'b1, 32'hC, 32'h4, EBRK, 1'b0);
    chk_status("ebreak_bad", 32'd2, 1'b1, ERR_SEQ, 1'b0);

    // Reset while entries are queued and the checker is in ERR.
    do_reset();
    chk("midrst_valid", 32'(tif.trace_valid), 32'd0);
    chk("midrst_tpc",   tif.trace_pc,         32'd0);
    chk_status("midrst", 32'd0, 1'b0, ERR_NONE, 1'b0);
    step(1'b1, 32'h0, 32'h0, NOP, 1'b0);
    chk_status("midrst_restart", 32'd1, 1'b0, ERR_NONE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
